// File: rtl/mcyc_control.sv
// Multi-cycle control FSM for the MIPS-subset CPU: sequences IF/ID/EXE/MEM/WB
// and drives every datapath enable and mux select combinationally from state and IR.
module mcyc_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       zero,
    output logic       wpc,
    output logic       wir,
    output logic       wmem,
    output logic       wreg,
    output logic       iord,
    output logic       regrt,
    output logic       m2reg,
    output logic       jal,
    output logic       sext,
    output logic [3:0] aluc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsource,
    output logic [2:0] state
);

    localparam logic [2:0] S_IF  = 3'b000;
    localparam logic [2:0] S_ID  = 3'b001;
    localparam logic [2:0] S_EXE = 3'b010;
    localparam logic [2:0] S_MEM = 3'b011;
    localparam logic [2:0] S_WB  = 3'b100;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_LUI = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1111;

    logic [2:0] r_state;
    logic [2:0] w_state_next;

    logic       w_alu_r, w_shift, w_jr, w_alu_i;
    logic       w_lw, w_sw, w_beq, w_bne, w_j, w_jal;
    logic       w_sext, w_legal, w_taken;
    logic [3:0] w_aluc;
    logic [1:0] w_exe_srca, w_exe_srcb;
    logic [3:0] w_exe_aluc;

    // Instruction decode: class flags plus the ALU op implied by op/func.
    always_comb begin
        w_alu_r = 1'b0;
        w_shift = 1'b0;
        w_jr    = 1'b0;
        w_alu_i = 1'b0;
        w_lw    = 1'b0;
        w_sw    = 1'b0;
        w_beq   = 1'b0;
        w_bne   = 1'b0;
        w_j     = 1'b0;
        w_jal   = 1'b0;
        w_sext  = 1'b0;
        w_aluc  = ALU_ADD;
        case (op)
            6'b000000: begin
                case (func)
                    6'b100000: begin w_alu_r = 1'b1; w_aluc = ALU_ADD; end
                    6'b100010: begin w_alu_r = 1'b1; w_aluc = ALU_SUB; end
                    6'b100100: begin w_alu_r = 1'b1; w_aluc = ALU_AND; end
                    6'b100101: begin w_alu_r = 1'b1; w_aluc = ALU_OR;  end
                    6'b100110: begin w_alu_r = 1'b1; w_aluc = ALU_XOR; end
                    6'b000000: begin w_alu_r = 1'b1; w_shift = 1'b1; w_aluc = ALU_SLL; end
                    6'b000010: begin w_alu_r = 1'b1; w_shift = 1'b1; w_aluc = ALU_SRL; end
                    6'b000011: begin w_alu_r = 1'b1; w_shift = 1'b1; w_aluc = ALU_SRA; end
                    6'b001000: w_jr = 1'b1;
                    default:   ;
                endcase
            end
            6'b001000: begin w_alu_i = 1'b1; w_sext = 1'b1; w_aluc = ALU_ADD; end
            6'b001100: begin w_alu_i = 1'b1; w_aluc = ALU_AND; end
            6'b001101: begin w_alu_i = 1'b1; w_aluc = ALU_OR;  end
            6'b001110: begin w_alu_i = 1'b1; w_aluc = ALU_XOR; end
            6'b001111: begin w_alu_i = 1'b1; w_aluc = ALU_LUI; end
            6'b100011: begin w_lw  = 1'b1; w_sext = 1'b1; end
            6'b101011: begin w_sw  = 1'b1; w_sext = 1'b1; end
            6'b000100: begin w_beq = 1'b1; w_sext = 1'b1; w_aluc = ALU_SUB; end
            6'b000101: begin w_bne = 1'b1; w_sext = 1'b1; w_aluc = ALU_SUB; end
            6'b000010: w_j   = 1'b1;
            6'b000011: w_jal = 1'b1;
            default:   ;
        endcase
    end

    assign w_legal = w_alu_r | w_jr | w_alu_i | w_lw | w_sw | w_beq | w_bne | w_j | w_jal;
    assign w_taken = (w_beq & zero) | (w_bne & ~zero);

    // EXE operand selection; WB repeats it so the unconditionally loaded ALUout stays stable.
    always_comb begin
        w_exe_srca = 2'b00;
        w_exe_srcb = 2'b00;
        w_exe_aluc = ALU_ADD;
        if (w_alu_r) begin
            w_exe_srca = w_shift ? 2'b10 : 2'b01;
            w_exe_srcb = 2'b00;
            w_exe_aluc = w_aluc;
        end else if (w_alu_i | w_lw | w_sw) begin
            w_exe_srca = 2'b01;
            w_exe_srcb = 2'b10;
            w_exe_aluc = w_aluc;
        end else if (w_beq | w_bne) begin
            w_exe_srca = 2'b01;
            w_exe_srcb = 2'b00;
            w_exe_aluc = ALU_SUB;
        end
    end

    always_comb begin
        wpc          = 1'b0;
        wir          = 1'b0;
        wmem         = 1'b0;
        wreg         = 1'b0;
        iord         = 1'b0;
        regrt        = 1'b0;
        m2reg        = 1'b0;
        jal          = 1'b0;
        sext         = 1'b0;
        aluc         = ALU_ADD;
        alusrca      = 2'b00;
        alusrcb      = 2'b00;
        pcsource     = 2'b00;
        w_state_next = S_IF;
        case (r_state)
            S_IF: begin
                wir          = 1'b1;
                wpc          = 1'b1;
                alusrcb      = 2'b01;
                w_state_next = S_ID;
            end
            S_ID: begin
                alusrcb = 2'b11;
                sext    = w_sext;
                if (w_j | w_jal) begin
                    wpc      = 1'b1;
                    pcsource = 2'b11;
                    wreg     = w_jal;
                    jal      = w_jal;
                end else if (w_jr) begin
                    wpc      = 1'b1;
                    pcsource = 2'b10;
                end else if (w_legal) begin
                    w_state_next = S_EXE;
                end
            end
            S_EXE: begin
                alusrca = w_exe_srca;
                alusrcb = w_exe_srcb;
                aluc    = w_exe_aluc;
                sext    = w_sext;
                if (w_beq | w_bne) begin
                    wpc      = w_taken;
                    pcsource = w_taken ? 2'b01 : 2'b00;
                end else if (w_lw | w_sw) begin
                    w_state_next = S_MEM;
                end else if (w_alu_r | w_alu_i) begin
                    w_state_next = S_WB;
                end
            end
            S_MEM: begin
                sext = w_sext;
                if (w_lw | w_sw) begin
                    iord = 1'b1;
                    wmem = w_sw;
                end
                if (w_lw) w_state_next = S_WB;
            end
            S_WB: begin
                alusrca = w_exe_srca;
                alusrcb = w_exe_srcb;
                aluc    = w_exe_aluc;
                sext    = w_sext;
                wreg    = w_alu_r | w_alu_i | w_lw;
                regrt   = w_alu_i | w_lw;
                m2reg   = w_lw;
            end
            default: ;
        endcase
        if (!rst) begin
            wpc  = 1'b0;
            wir  = 1'b0;
            wmem = 1'b0;
            wreg = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IF;
        else      r_state <= w_state_next;
    end

    assign state = r_state;

endmodule

// File: tb/tb_mcyc_control.sv
// Directed bench for mcyc_control: walks each instruction class through its
// state sequence and compares control outputs against hand-derived values.
module tb_mcyc_control;

    logic       clk;
    logic       rst;
    logic [5:0] op;
    logic [5:0] func;
    logic       zero;
    logic       wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, sext;
    logic [3:0] aluc;
    logic [1:0] alusrca, alusrcb, pcsource;
    logic [2:0] state;

    int n_checks = 0;
    int n_errors = 0;

    mcyc_control dut (
        .clk      (clk),
        .rst      (rst),
        .op       (op),
        .func     (func),
        .zero     (zero),
        .wpc      (wpc),
        .wir      (wir),
        .wmem     (wmem),
        .wreg     (wreg),
        .iord     (iord),
        .regrt    (regrt),
        .m2reg    (m2reg),
        .jal      (jal),
        .sext     (sext),
        .aluc     (aluc),
        .alusrca  (alusrca),
        .alusrcb  (alusrcb),
        .pcsource (pcsource),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance one rising edge, then let outputs settle before sampling.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_instr(input logic [5:0] o, input logic [5:0] f, input logic z);
        op   = o;
        func = f;
        zero = z;
        #1;
    endtask

    task automatic check_writes(input string tag, input logic [3:0] exp_pc_ir_mem_reg);
        check_eq({tag, ".wpc"},  {7'd0, wpc},  {7'd0, exp_pc_ir_mem_reg[3]});
        check_eq({tag, ".wir"},  {7'd0, wir},  {7'd0, exp_pc_ir_mem_reg[2]});
        check_eq({tag, ".wmem"}, {7'd0, wmem}, {7'd0, exp_pc_ir_mem_reg[1]});
        check_eq({tag, ".wreg"}, {7'd0, wreg}, {7'd0, exp_pc_ir_mem_reg[0]});
    endtask

    initial begin
        rst  = 1'b0;
        op   = 6'b100011;
        func = 6'b000000;
        zero = 1'b0;

        // Reset held for three edges with lw on the IR.
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("rst.state", {5'd0, state}, 8'h00);
            check_writes("rst", 4'b0000);
        end
        rst = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check_writes("if", 4'b1100);
        check_eq("if.alusrcb", {6'd0, alusrcb}, 8'h01);

        // lw: IF ID EXE MEM WB IF
        tick(); check_eq("lw.id", {5'd0, state}, 8'h01);
        check_eq("lw.id.alusrcb", {6'd0, alusrcb}, 8'h03);
        tick(); check_eq("lw.exe", {5'd0, state}, 8'h02);
        check_eq("lw.exe.alusrca", {6'd0, alusrca}, 8'h01);
        check_eq("lw.exe.alusrcb", {6'd0, alusrcb}, 8'h02);
        check_eq("lw.exe.sext", {7'd0, sext}, 8'h01);
        tick(); check_eq("lw.mem", {5'd0, state}, 8'h03);
        check_eq("lw.mem.iord", {7'd0, iord}, 8'h01);
        check_writes("lw.mem", 4'b0000);
        tick(); check_eq("lw.wb", {5'd0, state}, 8'h04);
        check_writes("lw.wb", 4'b0001);
        check_eq("lw.wb.m2reg", {7'd0, m2reg}, 8'h01);
        check_eq("lw.wb.regrt", {7'd0, regrt}, 8'h01);
        tick(); check_eq("lw.done", {5'd0, state}, 8'h00);

        // sw: 4 cycles, wmem only in MEM
        set_instr(6'b101011, 6'b000000, 1'b0);
        tick(); check_writes("sw.id", 4'b0000);
        tick(); check_writes("sw.exe", 4'b0000);
        tick(); check_eq("sw.mem", {5'd0, state}, 8'h03);
        check_writes("sw.mem", 4'b0010);
        check_eq("sw.mem.iord", {7'd0, iord}, 8'h01);
        tick(); check_eq("sw.done", {5'd0, state}, 8'h00);

        // add: writes rd in WB
        set_instr(6'b000000, 6'b100000, 1'b0);
        tick(); tick();
        check_eq("add.exe.alusrca", {6'd0, alusrca}, 8'h01);
        check_eq("add.exe.alusrcb", {6'd0, alusrcb}, 8'h00);
        tick(); check_eq("add.wb", {5'd0, state}, 8'h04);
        check_writes("add.wb", 4'b0001);
        check_eq("add.wb.regrt", {7'd0, regrt}, 8'h00);
        check_eq("add.wb.aluc", {4'd0, aluc}, 8'h00);
        tick(); check_eq("add.done", {5'd0, state}, 8'h00);

        // sra: shift amount operand, held through WB
        set_instr(6'b000000, 6'b000011, 1'b0);
        tick(); tick();
        check_eq("sra.exe.alusrca", {6'd0, alusrca}, 8'h02);
        check_eq("sra.exe.aluc", {4'd0, aluc}, 8'h0f);
        tick();
        check_eq("sra.wb.alusrca", {6'd0, alusrca}, 8'h02);
        check_eq("sra.wb.aluc", {4'd0, aluc}, 8'h0f);
        tick();

        // ori: zero-extended immediate, writes rt
        set_instr(6'b001101, 6'b000000, 1'b0);
        tick(); tick();
        check_eq("ori.exe.alusrcb", {6'd0, alusrcb}, 8'h02);
        check_eq("ori.exe.aluc", {4'd0, aluc}, 8'h05);
        check_eq("ori.exe.sext", {7'd0, sext}, 8'h00);
        tick(); check_eq("ori.wb.regrt", {7'd0, regrt}, 8'h01);
        tick();

        // beq taken; zero high in ID must not matter there
        set_instr(6'b000100, 6'b000000, 1'b1);
        tick(); check_writes("beq1.id", 4'b0000);
        check_eq("beq1.id.sext", {7'd0, sext}, 8'h01);
        tick(); check_eq("beq1.exe", {5'd0, state}, 8'h02);
        check_writes("beq1.exe", 4'b1000);
        check_eq("beq1.exe.pcsource", {6'd0, pcsource}, 8'h01);
        check_eq("beq1.exe.aluc", {4'd0, aluc}, 8'h04);
        tick(); check_eq("beq1.done", {5'd0, state}, 8'h00);

        // beq not taken
        set_instr(6'b000100, 6'b000000, 1'b0);
        tick(); tick();
        check_writes("beq0.exe", 4'b0000);
        tick(); check_eq("beq0.done", {5'd0, state}, 8'h00);

        // bne taken on zero = 0
        set_instr(6'b000101, 6'b000000, 1'b0);
        tick(); tick();
        check_writes("bne0.exe", 4'b1000);
        check_eq("bne0.exe.pcsource", {6'd0, pcsource}, 8'h01);
        tick();

        // j
        set_instr(6'b000010, 6'b000000, 1'b0);
        tick(); check_writes("j.id", 4'b1000);
        check_eq("j.id.pcsource", {6'd0, pcsource}, 8'h03);
        tick(); check_eq("j.done", {5'd0, state}, 8'h00);

        // jal
        set_instr(6'b000011, 6'b000000, 1'b0);
        tick(); check_writes("jal.id", 4'b1001);
        check_eq("jal.id.jal", {7'd0, jal}, 8'h01);
        check_eq("jal.id.pcsource", {6'd0, pcsource}, 8'h03);
        tick(); check_eq("jal.done", {5'd0, state}, 8'h00);

        // jr
        set_instr(6'b000000, 6'b001000, 1'b0);
        tick(); check_writes("jr.id", 4'b1000);
        check_eq("jr.id.pcsource", {6'd0, pcsource}, 8'h02);
        tick(); check_eq("jr.done", {5'd0, state}, 8'h00);

        // Reset asserted while lw sits in MEM
        set_instr(6'b100011, 6'b000000, 1'b0);
        tick(); tick(); tick();
        check_eq("rstlw.mem", {5'd0, state}, 8'h03);
        rst = 1'b0;
        #1;
        check_writes("rstlw.mem.held", 4'b0000);
        tick(); check_eq("rstlw.state", {5'd0, state}, 8'h00);
        check_writes("rstlw.after", 4'b0000);
        rst = 1'b1;
        #1;
        check_writes("rstlw.if", 4'b1100);
        tick(); check_eq("rstlw.id", {5'd0, state}, 8'h01);
        tick(); tick(); tick(); tick();
        check_eq("rstlw.refetch", {5'd0, state}, 8'h00);

        // Undefined opcode behaves as a nop
        set_instr(6'b111111, 6'b000000, 1'b0);
        tick(); check_eq("undef.id", {5'd0, state}, 8'h01);
        check_writes("undef.id", 4'b0000);
        tick(); check_eq("undef.done", {5'd0, state}, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
